// File: rtl/sdmac_pkg.sv
// sdmac_pkg: shared types and register map for the SDMAC register cycle decoder.
`default_nettype none

package sdmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WDREQ  = 3'd3,
    ST_ACK    = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DEC_LOCAL    = 2'd0,
    DEC_WD       = 2'd1,
    DEC_UNMAPPED = 2'd2
  } dec_t;

  localparam int unsigned REG_STRIDE      = 4;
  localparam int unsigned DEFAULT_WD_BASE = 32'h40;

  localparam logic [7:0] REG_CNTR   = 8'h08;
  localparam logic [7:0] REG_DAWR   = 8'h0C;
  localparam logic [7:0] REG_ST_DMA = 8'h10;
  localparam logic [7:0] REG_SP_DMA = 8'h14;
  localparam logic [7:0] REG_CINT   = 8'h18;
  localparam logic [7:0] REG_ISTR   = 8'h1C;
  localparam logic [7:0] REG_FLUSH  = 8'h3C;

endpackage

`default_nettype wire

// File: rtl/reg_cycle_decoder_if.sv
// reg_cycle_decoder_if: CPU-side strobes, register selects and WD33C93 handshake.
`default_nettype none

interface reg_cycle_decoder_if #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned NUM_REGS = 16
);
  logic [ADDR_W-1:0]   addr;
  logic                dmac_n;
  logic                as_n;
  logic                r_w;
  logic                wdregack;
  logic [NUM_REGS-1:0] reg_sel;
  logic                reg_rd;
  logic                reg_wr;
  logic                wdregreq;
  logic                dsack_n;
  logic                berr_n;
  logic                busy;

  modport master (
    output addr, dmac_n, as_n, r_w, wdregack,
    input  reg_sel, reg_rd, reg_wr, wdregreq, dsack_n, berr_n, busy
  );

  modport slave (
    input  addr, dmac_n, as_n, r_w, wdregack,
    output reg_sel, reg_rd, reg_wr, wdregreq, dsack_n, berr_n, busy
  );
endinterface

`default_nettype wire

// File: rtl/sig_sync.sv
// sig_sync: STAGES-deep synchroniser for an active-low strobe; resets to the inactive level.
`default_nettype none

module sig_sync #(
  parameter int unsigned STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

`default_nettype wire

// File: rtl/reg_cycle_decoder.sv
// reg_cycle_decoder: clocked SDMAC register decoder with wait states and a WD33C93 request/ack handshake.
`default_nettype none

module reg_cycle_decoder
  import sdmac_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WD_BASE     = DEFAULT_WD_BASE,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned WD_TIMEOUT  = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  reg_cycle_decoder_if.slave bus
);
  localparam int unsigned CNT_MAX = (WAIT_STATES > WD_TIMEOUT) ? WAIT_STATES : WD_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((WD_TIMEOUT > 0) ? WD_TIMEOUT - 1 : 0);
  localparam int unsigned SB = $clog2(REG_STRIDE);
  localparam logic [ADDR_W-1:0] WD_BASE_A = ADDR_W'(WD_BASE);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              ack_d;
  logic              s_as, s_dmac, valid;
  dec_t              dec;
  logic              in_local;
  logic [NUM_REGS-1:0] sel_onehot;

  sig_sync #(.STAGES(SYNC_STAGES)) u_sync_as   (.clk(clk), .rst(rst), .d(bus.as_n),   .q(s_as));
  sig_sync #(.STAGES(SYNC_STAGES)) u_sync_dmac (.clk(clk), .rst(rst), .d(bus.dmac_n), .q(s_dmac));

  assign valid = ~s_as & ~s_dmac;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      rd_q   <= 1'b0;
      ack_d  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ack_d <= (state == ST_ACK);
      if (state == ST_IDLE && valid) begin
        addr_q <= bus.addr;
        rd_q   <= bus.r_w;
      end
    end
  end

  always_comb begin
    dec = DEC_UNMAPPED;
    if (addr_q >= WD_BASE_A)
      dec = DEC_WD;
    else if (addr_q[SB-1:0] == '0 && 32'(addr_q[ADDR_W-1:SB]) < NUM_REGS)
      dec = DEC_LOCAL;
  end

  // An address strobe released before the acknowledge abandons the cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (valid) state_n = ST_DECODE;
      end
      ST_DECODE: begin
        cnt_n = '0;
        if (s_as)                    state_n = ST_IDLE;
        else if (dec == DEC_LOCAL)   state_n = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        else if (dec == DEC_WD)      state_n = ST_WDREQ;
        else                         state_n = ST_ACK;
      end
      ST_WAIT: begin
        if (s_as) begin
          state_n = ST_IDLE;
        end else if (cnt == WAIT_LAST) begin
          state_n = ST_ACK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_WDREQ: begin
        if (s_as) begin
          state_n = ST_IDLE;
        end else if (bus.wdregack) begin
          state_n = ST_ACK;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          state_n = ST_ERR;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_ACK, ST_ERR: begin
        cnt_n = '0;
        if (s_as) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign sel_onehot = NUM_REGS'(1) << addr_q[ADDR_W-1:SB];
  assign in_local   = (state == ST_DECODE || state == ST_WAIT || state == ST_ACK) && (dec == DEC_LOCAL);

  assign bus.reg_sel  = in_local ? sel_onehot : '0;
  assign bus.reg_rd   = in_local & rd_q;
  assign bus.reg_wr   = (state == ST_ACK) & ~ack_d & (dec == DEC_LOCAL) & ~rd_q;
  assign bus.wdregreq = (state == ST_WDREQ);
  assign bus.dsack_n  = (state != ST_ACK);
  assign bus.berr_n   = (state != ST_ERR);
  assign bus.busy     = (state != ST_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_reg_cycle_decoder.sv
// tb_reg_cycle_decoder: table-driven local/unmapped accesses plus WD handshake, timeout, abort and reset sequences.
`default_nettype none

module tb_reg_cycle_decoder;
  import sdmac_pkg::*;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned NUM_REGS    = 16;
  localparam int unsigned WAIT_STATES = 2;
  localparam int unsigned WD_TIMEOUT  = 255;
  localparam int unsigned SYNC_STAGES = 2;
  localparam logic [31:0] IDLE_OUTS   = 32'h0000_0006;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_cycle_decoder_if #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) bus ();

  reg_cycle_decoder #(
    .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .WD_BASE(DEFAULT_WD_BASE),
    .WAIT_STATES(WAIT_STATES), .WD_TIMEOUT(WD_TIMEOUT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [7:0]  addr;
    logic        rw;
    logic [15:0] sel;
    logic        rd;
    int          wr;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {10'h0, bus.reg_sel, bus.reg_rd, bus.reg_wr, bus.wdregreq, bus.dsack_n, bus.berr_n, bus.busy};
  endfunction

  task automatic go(input logic [7:0] a, input logic rw);
    bus.addr   = a;
    bus.r_w    = rw;
    bus.dmac_n = 1'b0;
    bus.as_n   = 1'b0;
  endtask

  task automatic finish_cycle(input string name, output int wr_extra);
    wr_extra   = 0;
    bus.as_n   = 1'b1;
    bus.dmac_n = 1'b1;
    for (int i = 0; i < 12 && bus.busy; i++) begin
      tick();
      if (bus.reg_wr) wr_extra++;
    end
    chk({name, " idle"}, outs(), IDLE_OUTS);
    tick();
    tick();
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!bus.wdregreq && k < 20) begin
      tick();
      k++;
    end
    chk({name, " req latency"}, k, 4);
  endtask

  initial begin
    vec_t vt[8];
    int lat, wrc, wrf, wx, n, bad, busy6;
    logic [15:0] seld, sela;
    logic rdd, rda;
    string nm;

    vt[0] = '{8'h08, 1'b1, 16'h0004, 1'b1, 0, 6};
    vt[1] = '{8'h3C, 1'b0, 16'h8000, 1'b0, 1, 6};
    vt[2] = '{8'h00, 1'b0, 16'h0001, 1'b0, 1, 6};
    vt[3] = '{8'h1C, 1'b1, 16'h0080, 1'b1, 0, 6};
    vt[4] = '{8'h09, 1'b1, 16'h0000, 1'b0, 0, 4};
    vt[5] = '{8'h0A, 1'b0, 16'h0000, 1'b0, 0, 4};
    vt[6] = '{8'h2C, 1'b0, 16'h0800, 1'b0, 1, 6};
    vt[7] = '{8'h3F, 1'b1, 16'h0000, 1'b0, 0, 4};

    // Strobes asserted during reset must not start a cycle.
    bus.addr = 8'h08; bus.r_w = 1'b1; bus.wdregack = 1'b0;
    bus.as_n = 1'b0;  bus.dmac_n = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset outs", outs(), IDLE_OUTS);
    bus.as_n = 1'b1; bus.dmac_n = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    chk("post reset outs", outs(), IDLE_OUTS);

    for (int i = 0; i < 8; i++) begin
      nm = $sformatf("vec%0d@%0h", i, vt[i].addr);
      go(vt[i].addr, vt[i].rw);
      lat = -1; wrc = 0; wrf = 0; seld = '0; sela = '0; rdd = 1'b0; rda = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (bus.reg_wr) wrc++;
        if (k == 3) begin
          seld = bus.reg_sel;
          rdd  = bus.reg_rd;
        end
        if (lat < 0 && !bus.dsack_n) begin
          lat  = k;
          sela = bus.reg_sel;
          rda  = bus.reg_rd;
          wrf  = int'(bus.reg_wr);
        end
        if (lat >= 0 && k >= lat + 2) break;
      end
      finish_cycle(nm, wx);
      wrc += wx;
      chk({nm, " dsack latency"}, lat, vt[i].lat);
      chk({nm, " sel decode"}, seld, vt[i].sel);
      chk({nm, " rd decode"}, rdd, vt[i].rd);
      chk({nm, " sel ack"}, sela, vt[i].sel);
      chk({nm, " rd ack"}, rda, vt[i].rd);
      chk({nm, " wr first ack"}, wrf, vt[i].wr);
      chk({nm, " wr count"}, wrc, vt[i].wr);
    end

    // WD access acknowledged 10 cycles after the request rises.
    go(8'h40, 1'b1);
    wait_req("wd40");
    bad = 0;
    repeat (10) begin
      if (!bus.wdregreq || !bus.dsack_n || bus.reg_sel != 0 || bus.reg_rd) bad++;
      tick();
    end
    chk("wd40 hold", bad, 0);
    bus.wdregack = 1'b1;
    tick();
    bus.wdregack = 1'b0;
    chk("wd40 ack outs", outs(), {10'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    finish_cycle("wd40", wx);
    chk("wd40 wr", wx, 0);

    // WD timeout with no acknowledge.
    go(8'h44, 1'b0);
    wait_req("wd44to");
    n = 0; bad = 0;
    while (bus.berr_n && n < 300) begin
      if (!bus.dsack_n) bad++;
      tick();
      n++;
    end
    chk("wd44 timeout cycles", n, 255);
    chk("wd44 timeout outs", outs(), {10'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    chk("wd44 dsack during wait", bad, 0);
    finish_cycle("wd44to", wx);

    // Acknowledge in the same cycle as the timeout: acknowledge wins.
    go(8'h44, 1'b1);
    wait_req("wd44race");
    repeat (254) tick();
    chk("wd44race last req", bus.wdregreq, 1'b1);
    bus.wdregack = 1'b1;
    tick();
    bus.wdregack = 1'b0;
    chk("wd44race outs", outs(), {10'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    finish_cycle("wd44race", wx);

    // Chip select inactive: address strobe alone must not start a cycle.
    bus.addr = 8'h08; bus.r_w = 1'b1; bus.dmac_n = 1'b1; bus.as_n = 1'b0;
    bad = 0;
    repeat (8) begin
      tick();
      if (bus.busy) bad++;
    end
    chk("dmac high busy", bad, 0);
    bus.as_n = 1'b1;
    repeat (3) tick();

    // Abort: strobe released so it is seen during WAIT.
    go(8'h0C, 1'b0);
    repeat (3) tick();
    chk("abort decode sel", bus.reg_sel, 16'h0008);
    bus.as_n = 1'b1; bus.dmac_n = 1'b1;
    bad = 0; busy6 = -1;
    for (int k = 4; k <= 10; k++) begin
      tick();
      if (!bus.dsack_n || bus.reg_wr) bad++;
      if (k == 6) busy6 = int'(bus.busy);
    end
    chk("abort no ack or wr", bad, 0);
    chk("abort idle at k6", busy6, 0);
    chk("abort outs", outs(), IDLE_OUTS);

    // Reset during WDREQ; a late acknowledge must be ignored.
    go(8'h40, 1'b0);
    wait_req("rstwd");
    repeat (3) tick();
    rst = 1'b1; bus.as_n = 1'b1; bus.dmac_n = 1'b1;
    tick();
    chk("rst in wdreq outs", outs(), IDLE_OUTS);
    rst = 1'b0;
    tick();
    bus.wdregack = 1'b1;
    tick();
    bus.wdregack = 1'b0;
    bad = 0;
    repeat (4) begin
      tick();
      if (outs() != IDLE_OUTS) bad++;
    end
    chk("late wdregack ignored", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
